phase_freq_detector_fp_int: RTL and testbench
=============================================

Name: phase_freq_detector_fp_int

Overview:
- Tri-state phase-frequency detector (PFD) for the event-driven fixed-point PLL.
- Sits directly upstream of the charge pump and drives its 1-bit up and down command inputs.
- Compares rising edges of the digitised reference and feedback (divider) clocks, and produces UP/DOWN pulses with a programmable anti-dead-zone reset interval.
- Also reports the signed width of each completed pulse for loop diagnostics.

Parameters:
- reset_delay_param, 1: cycles both outputs stay high in RESET state. 0 = skip RESET and return to IDLE directly.
- width_param, 16: bit width of the pulse-width counter/output.
- lock_count_param, 16: consecutive in-window pulses required for lock (optional feature only).
- lock_window_param, 2: maximum pulse width, in cycles, counted as in-window (optional feature only).

Ports:
- clk  input  1  block clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- input_ref_digital  input  1  digitised reference clock level.
- input_fb_digital  input  1  digitised feedback (divided VCO) clock level.
- output_up_digital  output  1  UP command to charge pump.
- output_down_digital  output  1  DOWN command to charge pump.
- output_pulse_width  output  width_param  width in cycles of the last completed UP/DOWN pulse; saturating.
- output_pulse_sign  output  1  1 = last pulse was UP, 0 = DOWN.
- output_pulse_valid  output  1  one-cycle strobe when output_pulse_width/sign update.
- output_lock  output  1  lock indicator (see Optional Feature).

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- While reset is high:
  - state goes to IDLE and all outputs are 0.
  - Sample registers ref_s, ref_d, fb_s, fb_d are cleared.
  - The pulse counter and lock counter are cleared.
  - Reset asserted mid-pulse aborts the pulse with no valid strobe.
- Edge detect:
  - ref_s <= input_ref_digital, ref_d <= ref_s; ref_rise = ref_s & ~ref_d. Same scheme for fb.
  - An input already high when reset releases produces a rise 1 cycle later.
- Latency: an input rising at edge n gives rise=1 after edge n+1, and the output changes after edge n+2.
- FSM states: IDLE, UP, DOWN, RESET. Outputs are registered: up = (UP | RESET), down = (DOWN | RESET).
- IDLE transitions:
  - ref_rise & fb_rise → RESET (or stay IDLE if reset_delay_param = 0).
  - ref_rise only → UP.
  - fb_rise only → DOWN.
- UP transitions:
  - fb_rise → RESET (IDLE if delay = 0).
  - Further ref_rise is ignored; stay UP.
- DOWN: mirror image of UP.
- RESET: the delay counter counts reset_delay_param cycles, then → IDLE. Any edges arriving during RESET are discarded.
- Pulse width:
  - The counter clears on entry to UP/DOWN and increments each cycle spent in UP/DOWN, saturating at 2^width_param − 1.
  - The count is a plain cycle count of UP/DOWN residency and does not include RESET cycles.
  - On exit from UP/DOWN: output_pulse_width <= count, output_pulse_sign <= (state == UP), and output_pulse_valid pulses 1 cycle.
  - A simultaneous-edge entry to RESET from IDLE reports width 0, sign 0, valid 1.
- Outputs output_pulse_width/output_pulse_sign hold their value between strobes.

Optional Feature:
- Macro: PFD_LOCK_DETECT_EN.
- With the macro:
  - A lock counter (clog2(lock_count_param+1) bits) increments on each valid strobe with width ≤ lock_window_param, saturating at lock_count_param.
  - A strobe with width > lock_window_param clears the counter.
  - output_lock = (counter == lock_count_param), registered. It deasserts the cycle after an out-of-window strobe.
- Without the macro: output_lock is tied 0, and no lock counter logic exists.

Decomposition:
- Shared package pll_pkg:
  - pfd_state_t enum {IDLE, UP, DOWN, RESET} as 2-bit, usable by the charge pump testbench.
  - PFD_WIDTH_DEFAULT constant.
- One sub-module, pfd_edge_detect: the 2-flop sample plus rise logic, instantiated twice (ref and fb).

Test Plan:
1. Ref leads fb: ref rises at cycle 10, fb at cycle 15, delay=1.
   - up=1 cycles 12–17.
   - down=1 at cycle 17 only (RESET).
   - valid at cycle 17 with width=5, sign=1.
2. Fb leads ref by 3 cycles → mirror of scenario 1: down pulse, width=3, sign=0, up high only in the RESET cycle.
3. Both rise in the same cycle, delay=2 → up=down=1 for exactly 2 cycles; valid with width=0, sign=0.
4. Boundary cases:
   - delay=0 with ref leading by 4: up for 4 cycles, then IDLE with no both-high cycle.
   - width_param=4 with fb lagging 20 cycles: width saturates at 15.
   - Reset asserted during UP: up=0 next cycle, no valid strobe.
   - Ref edge during RESET is dropped: the FSM returns to IDLE with no new UP pulse.
5. Lock with PFD_LOCK_DETECT_EN, lock_count_param=4, window=2:
   - Four pulses of width 1 → lock=1 after the 4th strobe.
   - A pulse of width 3 → lock=0 the next cycle.
   - Without the macro, lock stays 0 throughout.

Source files
------------

// File: rtl/pll_pkg.sv
// Shared PLL definitions: PFD state encoding and default counter width.
// The state enum is kept 2-bit so charge-pump benches can decode it directly.
package pll_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UP    = 2'd1,
    DOWN  = 2'd2,
    RESET = 2'd3
  } pfd_state_t;

  localparam int unsigned PFD_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/pfd_edge_detect.sv
// Two-flop level sampler with rising-edge detect for one digitised clock input.
// An input already high at reset release reports a rise one cycle later.
module pfd_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic s;
  logic d;

  always_ff @(posedge clk) begin
    if (reset) begin
      s <= 1'b0;
      d <= 1'b0;
    end else begin
      s <= level;
      d <= s;
    end
  end

  assign rise = s & ~d;

endmodule

// File: rtl/phase_freq_detector_fp_int.sv
// Tri-state PFD with anti-dead-zone reset interval and signed pulse-width report.
// Optional lock detector is built only when PFD_LOCK_DETECT_EN is defined.
module phase_freq_detector_fp_int
  import pll_pkg::*;
#(
  parameter int unsigned reset_delay_param = 1,
  parameter int unsigned width_param       = PFD_WIDTH_DEFAULT,
  parameter int unsigned lock_count_param  = 16,
  parameter int unsigned lock_window_param = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   input_ref_digital,
  input  logic                   input_fb_digital,
  output logic                   output_up_digital,
  output logic                   output_down_digital,
  output logic [width_param-1:0] output_pulse_width,
  output logic                   output_pulse_sign,
  output logic                   output_pulse_valid,
  output logic                   output_lock
);

  localparam int unsigned DW = (reset_delay_param > 0) ? $clog2(reset_delay_param + 1) : 1;
  localparam logic [width_param-1:0] CNT_MAX = '1;
  localparam pfd_state_t AFTER_MATCH = (reset_delay_param == 0) ? IDLE : RESET;

  logic ref_rise;
  logic fb_rise;

  pfd_edge_detect u_ref_edge (
    .clk   (clk),
    .reset (reset),
    .level (input_ref_digital),
    .rise  (ref_rise)
  );

  pfd_edge_detect u_fb_edge (
    .clk   (clk),
    .reset (reset),
    .level (input_fb_digital),
    .rise  (fb_rise)
  );

  pfd_state_t             state;
  pfd_state_t             next_state;
  logic                   report;
  logic [width_param-1:0] cnt;
  logic [DW-1:0]          dly_cnt;

  always_comb begin
    next_state = state;
    report     = 1'b0;
    case (state)
      IDLE: begin
        if (ref_rise && fb_rise) begin
          next_state = AFTER_MATCH;
          report     = 1'b1;
        end else if (ref_rise) begin
          next_state = UP;
        end else if (fb_rise) begin
          next_state = DOWN;
        end
      end
      UP: begin
        if (fb_rise) begin
          next_state = AFTER_MATCH;
          report     = 1'b1;
        end
      end
      DOWN: begin
        if (ref_rise) begin
          next_state = AFTER_MATCH;
          report     = 1'b1;
        end
      end
      RESET: begin
        if (dly_cnt >= DW'(reset_delay_param)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // cnt is preloaded to 1 on entry so the value reported at exit equals UP/DOWN residency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      cnt                 <= '0;
      dly_cnt             <= '0;
      output_up_digital   <= 1'b0;
      output_down_digital <= 1'b0;
      output_pulse_width  <= '0;
      output_pulse_sign   <= 1'b0;
      output_pulse_valid  <= 1'b0;
    end else begin
      state               <= next_state;
      output_up_digital   <= (next_state == UP)   || (next_state == RESET);
      output_down_digital <= (next_state == DOWN) || (next_state == RESET);
      output_pulse_valid  <= report;
      if (report) begin
        output_pulse_width <= (state == IDLE) ? '0 : cnt;
        output_pulse_sign  <= (state == UP);
      end
      if ((next_state != state) && ((next_state == UP) || (next_state == DOWN))) begin
        cnt <= width_param'(1);
      end else if ((next_state == state) && ((state == UP) || (state == DOWN)) &&
                   (cnt != CNT_MAX)) begin
        cnt <= cnt + width_param'(1);
      end
      if ((next_state == RESET) && (state != RESET)) begin
        dly_cnt <= DW'(1);
      end else if (state == RESET) begin
        dly_cnt <= dly_cnt + DW'(1);
      end
    end
  end

`ifdef PFD_LOCK_DETECT_EN
  localparam int unsigned LW = $clog2(lock_count_param + 1);

  logic [LW-1:0] lock_cnt;
  logic [LW-1:0] lock_cnt_next;
  logic          lock_q;

  always_comb begin
    lock_cnt_next = lock_cnt;
    if (output_pulse_valid) begin
      if (output_pulse_width <= width_param'(lock_window_param)) begin
        if (lock_cnt != LW'(lock_count_param)) lock_cnt_next = lock_cnt + LW'(1);
      end else begin
        lock_cnt_next = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_cnt <= '0;
      lock_q   <= 1'b0;
    end else begin
      lock_cnt <= lock_cnt_next;
      lock_q   <= (lock_cnt_next == LW'(lock_count_param));
    end
  end

  assign output_lock = lock_q;
`else
  assign output_lock = 1'b0;
`endif

endmodule

// File: tb/tb_phase_freq_detector_fp_int.sv
// Scoreboard bench for phase_freq_detector_fp_int: directed edge scenarios on four
// differently parameterised instances; pulse reports are checked by a separate monitor.
module tb_phase_freq_detector_fp_int;

`ifdef PFD_LOCK_DETECT_EN
  localparam bit LK = 1'b1;
`else
  localparam bit LK = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] w;
    logic        s;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ref_v;
  logic [3:0] fb_v;
  wire  [3:0] up_v;
  wire  [3:0] dn_v;
  wire  [3:0] val_v;
  wire  [3:0] sign_v;
  wire  [3:0] lock_v;
  wire  [15:0] w0;
  wire  [15:0] w1;
  wire  [15:0] w2;
  wire  [3:0]  w3;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];

  always #5 clk = ~clk;

  phase_freq_detector_fp_int #(.reset_delay_param(1), .width_param(16),
                               .lock_count_param(4), .lock_window_param(2)) dut_a (
    .clk(clk), .reset(reset), .input_ref_digital(ref_v[0]), .input_fb_digital(fb_v[0]),
    .output_up_digital(up_v[0]), .output_down_digital(dn_v[0]), .output_pulse_width(w0),
    .output_pulse_sign(sign_v[0]), .output_pulse_valid(val_v[0]), .output_lock(lock_v[0]));

  phase_freq_detector_fp_int #(.reset_delay_param(2), .width_param(16)) dut_b (
    .clk(clk), .reset(reset), .input_ref_digital(ref_v[1]), .input_fb_digital(fb_v[1]),
    .output_up_digital(up_v[1]), .output_down_digital(dn_v[1]), .output_pulse_width(w1),
    .output_pulse_sign(sign_v[1]), .output_pulse_valid(val_v[1]), .output_lock(lock_v[1]));

  phase_freq_detector_fp_int #(.reset_delay_param(0), .width_param(16)) dut_c (
    .clk(clk), .reset(reset), .input_ref_digital(ref_v[2]), .input_fb_digital(fb_v[2]),
    .output_up_digital(up_v[2]), .output_down_digital(dn_v[2]), .output_pulse_width(w2),
    .output_pulse_sign(sign_v[2]), .output_pulse_valid(val_v[2]), .output_lock(lock_v[2]));

  phase_freq_detector_fp_int #(.reset_delay_param(1), .width_param(4)) dut_d (
    .clk(clk), .reset(reset), .input_ref_digital(ref_v[3]), .input_fb_digital(fb_v[3]),
    .output_up_digital(up_v[3]), .output_down_digital(dn_v[3]), .output_pulse_width(w3),
    .output_pulse_sign(sign_v[3]), .output_pulse_valid(val_v[3]), .output_lock(lock_v[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int id, input int c, input logic act,
                     input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d c=%0d got %b exp %b", name, id, c, act, exp);
    end
  endtask

  function automatic int q_size(input int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      2:       return q2.size();
      default: return q3.size();
    endcase
  endfunction

  // Monitor: every valid strobe must match the oldest queued expectation.
  task automatic pop_check(input int id);
    exp_t        e;
    logic [15:0] w;
    if (q_size(id) == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_strobe dut%0d got valid=1 exp none", id);
      return;
    end
    case (id)
      0:       begin e = q0.pop_front(); w = w0; end
      1:       begin e = q1.pop_front(); w = w1; end
      2:       begin e = q2.pop_front(); w = w2; end
      default: begin e = q3.pop_front(); w = {12'd0, w3}; end
    endcase
    checks += 2;
    if (w !== e.w) begin
      errors++;
      $display("FAIL pulse_width dut%0d got %0d exp %0d", id, w, e.w);
    end
    if (sign_v[id] !== e.s) begin
      errors++;
      $display("FAIL pulse_sign dut%0d got %b exp %b", id, sign_v[id], e.s);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (val_v[i] === 1'b1) pop_check(i);
    end
  end

  task automatic push_exp(input int id, input int w, input logic s);
    exp_t e;
    e.w = 16'(w);
    e.s = s;
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      2:       q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  // One pulse scenario: edges at cycles ra/fa, expected up/down windows, optional lock checks.
  task automatic scen(input int id, input int ra, input int fa, input int ulo, input int uhi,
                      input int dlo, input int dhi, input int len, input int lc,
                      input logic lb, input logic la);
    for (int c = 0; c <= len; c++) begin
      if (c == ra) ref_v[id] = 1'b1;
      if (c == fa) fb_v[id] = 1'b1;
      chk("up", id, c, up_v[id], (c >= ulo) && (c <= uhi));
      chk("down", id, c, dn_v[id], (c >= dlo) && (c <= dhi));
      if (c == lc) chk("lock_before", id, c, lock_v[id], lb);
      if (c == lc + 1) chk("lock_after", id, c, lock_v[id], la);
      tick();
    end
    ref_v[id] = 1'b0;
    fb_v[id]  = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ref_v = '0;
    fb_v  = '0;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      chk("rst_up", i, 0, up_v[i], 1'b0);
      chk("rst_down", i, 0, dn_v[i], 1'b0);
      chk("rst_valid", i, 0, val_v[i], 1'b0);
      chk("rst_lock", i, 0, lock_v[i], 1'b0);
    end
    reset = 1'b0;
    repeat (3) tick();

    // Ref leads fb by 5
    push_exp(0, 5, 1'b1);
    scen(0, 10, 15, 12, 17, 17, 17, 20, -9, 1'b0, 1'b0);
    // Fb leads ref by 3
    push_exp(0, 3, 1'b0);
    scen(0, 13, 10, 15, 15, 12, 15, 20, -9, 1'b0, 1'b0);
    // Simultaneous edges, two-cycle reset interval
    push_exp(1, 0, 1'b0);
    scen(1, 10, 10, 12, 13, 12, 13, 20, -9, 1'b0, 1'b0);
    // Zero reset interval: straight back to IDLE
    push_exp(2, 4, 1'b1);
    scen(2, 10, 14, 12, 15, 1, 0, 20, -9, 1'b0, 1'b0);
    // 4-bit counter saturates on a 20-cycle pulse
    push_exp(3, 15, 1'b1);
    scen(3, 10, 30, 12, 32, 32, 32, 36, -9, 1'b0, 1'b0);

    // Ref re-rises while in RESET: must be dropped
    push_exp(0, 2, 1'b1);
    for (int c = 0; c <= 20; c++) begin
      if (c == 10) ref_v[0] = 1'b1;
      if (c == 11) ref_v[0] = 1'b0;
      if (c == 12) fb_v[0] = 1'b1;
      if (c == 13) ref_v[0] = 1'b1;
      chk("drop_up", 0, c, up_v[0], (c >= 12) && (c <= 14));
      chk("drop_down", 0, c, dn_v[0], c == 14);
      tick();
    end
    ref_v[0] = 1'b0;
    fb_v[0]  = 1'b0;
    repeat (4) tick();

    // Reset mid-UP aborts without a strobe
    for (int c = 0; c <= 20; c++) begin
      if (c == 10) ref_v[0] = 1'b1;
      if (c == 14) begin
        reset    = 1'b1;
        ref_v[0] = 1'b0;
      end
      if (c == 16) reset = 1'b0;
      chk("abort_up", 0, c, up_v[0], (c >= 12) && (c <= 14));
      chk("abort_down", 0, c, dn_v[0], 1'b0);
      tick();
    end

    // Lock: four in-window width-1 pulses, then one out-of-window width-3 pulse
    for (int k = 1; k <= 4; k++) begin
      push_exp(0, 1, 1'b1);
      scen(0, 0, 1, 2, 3, 3, 3, 7, 3, 1'b0, (k == 4) ? LK : 1'b0);
    end
    push_exp(0, 3, 1'b1);
    scen(0, 0, 3, 2, 5, 5, 5, 9, 5, LK, 1'b0);

    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q_size(i) != 0) begin
        errors++;
        $display("FAIL missing_strobe dut%0d got %0d pending exp 0", i, q_size(i));
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
